// File: rtl/raizing_gp9001_pkg.sv
// Shared types for the GP9001 command-port bridges.
package raizing_gp9001_pkg;

  // One-hot GP9001 command selects; bit order matches the op-select outputs.
  typedef enum logic [5:0] {
    OP_NONE        = 6'b000000,
    OP_SET_RAM_PTR = 6'b000001,
    OP_WRITE_RAM   = 6'b000010,
    OP_READ_RAM_H  = 6'b000100,
    OP_READ_RAM_L  = 6'b001000,
    OP_SELECT_REG  = 6'b010000,
    OP_WRITE_REG   = 6'b100000
  } op_e;

  // Word offsets (A[3:1]) within the GP9001 window.
  localparam logic [2:0] OFS_PTR    = 3'b000;
  localparam logic [2:0] OFS_DATA_H = 3'b010;
  localparam logic [2:0] OFS_DATA_L = 3'b011;
  localparam logic [2:0] OFS_SEL    = 3'b100;
  localparam logic [2:0] OFS_REG    = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_DONE
  } state_e;

  function automatic logic op_is_read(input op_e op);
    return (op == OP_READ_RAM_H) || (op == OP_READ_RAM_L);
  endfunction

endpackage

// File: rtl/raizing_gp9001_decode.sv
// Offset/direction to GP9001 op decoder; shared by the CPU-side bridges.
module raizing_gp9001_decode
  import raizing_gp9001_pkg::*;
(
  input  logic [2:0] addr,
  input  logic       rnw,
  output op_e        op,
  output logic       mapped
);

  // Map each (offset, direction) pair onto at most one GP9001 op.
  always_comb begin
    op = OP_NONE;
    case (addr)
      OFS_PTR:    if (!rnw) op = OP_SET_RAM_PTR;
      OFS_DATA_H: op = rnw ? OP_READ_RAM_H : OP_WRITE_RAM;
      OFS_DATA_L: op = rnw ? OP_READ_RAM_L : OP_WRITE_RAM;
      OFS_SEL:    if (!rnw) op = OP_SELECT_REG;
      OFS_REG:    if (!rnw) op = OP_WRITE_REG;
      default:    op = OP_NONE;
    endcase
    mapped = (op != OP_NONE);
  end

endmodule

// File: rtl/raizing_gp9001_bridge.sv
// 68000-side initiator for the GP9001 command interface: turns one CPU bus
// cycle into at most one GP9001 op, waits for ACK (with timeout), and
// answers the CPU with DTACK and read data.
module raizing_gp9001_bridge
  import raizing_gp9001_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [15:0] UNMAPPED_DATA = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_CS,
  input  logic [2:0]  CPU_ADDR,
  input  logic        CPU_RNW,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACKn,
  output logic        GP9001CS,
  input  logic        GP9001ACK,
  output logic [15:0] GP9001DIN,
  input  logic [15:0] GP9001DOUT,
  output logic        GP9001_OP_SET_RAM_PTR,
  output logic        GP9001_OP_WRITE_RAM,
  output logic        GP9001_OP_READ_RAM_H,
  output logic        GP9001_OP_READ_RAM_L,
  output logic        GP9001_OP_SELECT_REG,
  output logic        GP9001_OP_WRITE_REG,
  output logic        TIMEOUT_ERR
);

  // Value of the wait counter on the last WAIT_ACK cycle before giving up.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  op_e         dec_op;
  logic        dec_mapped;

  state_e      state_q,  state_d;
  logic        cs_prev_q;
  op_e         op_lat_q, op_lat_d;
  logic [15:0] din_lat_q, din_lat_d;
  op_e         op_out_q, op_out_d;
  logic        gp_cs_q,  gp_cs_d;
  logic [15:0] gp_din_q, gp_din_d;
  logic [15:0] dout_q,   dout_d;
  logic        dtack_q,  dtack_d;   // active-low, drives CPU_DTACKn
  logic        err_q,    err_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [5:0]  op_bits;

  raizing_gp9001_decode u_decode (
    .addr   (CPU_ADDR),
    .rnw    (CPU_RNW),
    .op     (dec_op),
    .mapped (dec_mapped)
  );

  // Register FSM state and every output so nothing reaches the pins combinationally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cs_prev_q <= 1'b0;
      op_lat_q  <= OP_NONE;
      din_lat_q <= '0;
      op_out_q  <= OP_NONE;
      gp_cs_q   <= 1'b0;
      gp_din_q  <= '0;
      dout_q    <= '0;
      dtack_q   <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= CPU_CS;
      op_lat_q  <= op_lat_d;
      din_lat_q <= din_lat_d;
      op_out_q  <= op_out_d;
      gp_cs_q   <= gp_cs_d;
      gp_din_q  <= gp_din_d;
      dout_q    <= dout_d;
      dtack_q   <= dtack_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT_ACK/DONE sequence.
  always_comb begin
    state_d   = state_q;
    op_lat_d  = op_lat_q;
    din_lat_d = din_lat_q;
    op_out_d  = op_out_q;
    gp_cs_d   = gp_cs_q;
    gp_din_d  = gp_din_q;
    dout_d    = dout_q;
    dtack_d   = dtack_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (CPU_CS && !cs_prev_q) begin
          if (dec_mapped) begin
            op_lat_d  = dec_op;
            din_lat_d = CPU_DIN;
            state_d   = ST_ISSUE;
          end else begin
            dout_d  = UNMAPPED_DATA;
            dtack_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        gp_cs_d  = 1'b1;
        op_out_d = op_lat_q;
        gp_din_d = din_lat_q;
        cnt_d    = '0;
        state_d  = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        // ACK is tested before the counter so a same-cycle ACK beats the timeout.
        // DTACK is only raised if the CPU is still waiting for this cycle.
        if (GP9001ACK) begin
          gp_cs_d  = 1'b0;
          op_out_d = OP_NONE;
          if (op_is_read(op_lat_q)) dout_d = GP9001DOUT;
          dtack_d  = !CPU_CS;
          state_d  = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          gp_cs_d  = 1'b0;
          op_out_d = OP_NONE;
          dout_d   = UNMAPPED_DATA;
          err_d    = 1'b1;
          dtack_d  = !CPU_CS;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // DTACK still high here means the CPU already left; exit at once.
        if (!CPU_CS || dtack_q) begin
          dtack_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign op_bits = op_out_q;

  assign CPU_DOUT              = dout_q;
  assign CPU_DTACKn            = dtack_q;
  assign GP9001CS              = gp_cs_q;
  assign GP9001DIN             = gp_din_q;
  assign TIMEOUT_ERR           = err_q;
  assign GP9001_OP_SET_RAM_PTR = op_bits[0];
  assign GP9001_OP_WRITE_RAM   = op_bits[1];
  assign GP9001_OP_READ_RAM_H  = op_bits[2];
  assign GP9001_OP_READ_RAM_L  = op_bits[3];
  assign GP9001_OP_SELECT_REG  = op_bits[4];
  assign GP9001_OP_WRITE_REG   = op_bits[5];

endmodule

// File: tb/tb_raizing_gp9001_bridge.sv
// Scoreboard bench for raizing_gp9001_bridge: stimulus pushes expected GP9001
// ops and CPU completions; two monitors pop and compare.
module tb_raizing_gp9001_bridge;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CPU_CS = 1'b0;
  logic [2:0]  CPU_ADDR = '0;
  logic        CPU_RNW = 1'b1;
  logic [15:0] CPU_DIN = '0;
  logic [15:0] CPU_DOUT;
  logic        CPU_DTACKn;
  logic        GP9001CS;
  logic        GP9001ACK = 1'b0;
  logic [15:0] GP9001DIN;
  logic [15:0] GP9001DOUT = '0;
  logic        GP9001_OP_SET_RAM_PTR, GP9001_OP_WRITE_RAM, GP9001_OP_READ_RAM_H;
  logic        GP9001_OP_READ_RAM_L, GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG;
  logic        TIMEOUT_ERR;
  logic [5:0]  ops;

  raizing_gp9001_bridge #(.TIMEOUT(255), .UNMAPPED_DATA(16'hFFFF)) dut (
    .CLK(CLK), .RESET(RESET), .CPU_CS(CPU_CS), .CPU_ADDR(CPU_ADDR),
    .CPU_RNW(CPU_RNW), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT),
    .CPU_DTACKn(CPU_DTACKn), .GP9001CS(GP9001CS), .GP9001ACK(GP9001ACK),
    .GP9001DIN(GP9001DIN), .GP9001DOUT(GP9001DOUT),
    .GP9001_OP_SET_RAM_PTR(GP9001_OP_SET_RAM_PTR),
    .GP9001_OP_WRITE_RAM(GP9001_OP_WRITE_RAM),
    .GP9001_OP_READ_RAM_H(GP9001_OP_READ_RAM_H),
    .GP9001_OP_READ_RAM_L(GP9001_OP_READ_RAM_L),
    .GP9001_OP_SELECT_REG(GP9001_OP_SELECT_REG),
    .GP9001_OP_WRITE_REG(GP9001_OP_WRITE_REG),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  assign ops = {GP9001_OP_WRITE_REG, GP9001_OP_SELECT_REG, GP9001_OP_READ_RAM_L,
                GP9001_OP_READ_RAM_H, GP9001_OP_WRITE_RAM, GP9001_OP_SET_RAM_PTR};

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [5:0] op; logic [15:0] din; } gp_exp_t;
  typedef struct { logic [15:0] dout; logic err; int unsigned cyc; } cpu_exp_t;
  gp_exp_t  gp_q[$];
  cpu_exp_t cpu_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Model state: what the CPU should see as read data and error flag.
  logic [15:0] m_dout = '0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Address map as a lookup table: {offset, rnw} -> one-hot op (0 = unmapped).
  function automatic logic [5:0] spec_op(input logic [2:0] a, input logic rnw);
    case ({a, rnw})
      4'b000_0:          return 6'b000001;
      4'b010_0, 4'b011_0: return 6'b000010;
      4'b010_1:          return 6'b000100;
      4'b011_1:          return 6'b001000;
      4'b100_0:          return 6'b010000;
      4'b110_0:          return 6'b100000;
      default:           return 6'b000000;
    endcase
  endfunction

  // GP9001 responder: ACK after rsp_delay cycles of CS high (0 = never).
  int unsigned rsp_delay = 1;
  logic [15:0] rsp_data = '0;
  int unsigned seen = 0;
  always @(negedge CLK) begin
    if (RESET || !GP9001CS) begin
      GP9001ACK = 1'b0;
      seen = 0;
      GP9001DOUT = 16'($urandom);
    end else if (!GP9001ACK) begin
      seen++;
      if (rsp_delay != 0 && seen == rsp_delay) begin
        GP9001ACK = 1'b1;
        GP9001DOUT = rsp_data;
      end else begin
        GP9001DOUT = 16'($urandom);
      end
    end
  end

  // GP-side monitor: pop on CS rise, check hold while CS is up and idle ops after.
  logic    gp_prev = 1'b0;
  gp_exp_t gp_cur;
  always @(negedge CLK) begin
    if (RESET) begin
      gp_prev = 1'b0;
    end else begin
      if (GP9001CS && !gp_prev) begin
        if (gp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_gp_cs: got op %0h expected no request", ops);
        end else begin
          gp_cur = gp_q.pop_front();
          check("gp_op", {26'd0, ops}, {26'd0, gp_cur.op});
          check("gp_din", {16'd0, GP9001DIN}, {16'd0, gp_cur.din});
        end
      end else if (GP9001CS) begin
        check("gp_hold", {10'd0, ops, GP9001DIN}, {10'd0, gp_cur.op, gp_cur.din});
      end else if (gp_prev) begin
        check("gp_op_release", {26'd0, ops}, 32'd0);
      end
      gp_prev = GP9001CS;
    end
  end

  // CPU-side monitor: pop on DTACKn fall, check data, error flag and latency.
  logic     dt_prev = 1'b1;
  cpu_exp_t cpu_cur;
  always @(negedge CLK) begin
    if (!RESET && dt_prev && !CPU_DTACKn) begin
      if (cpu_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_dtack: got DTACKn 0 expected 1 (t=%0t)", $time);
      end else begin
        cpu_cur = cpu_q.pop_front();
        check("cpu_dout", {16'd0, CPU_DOUT}, {16'd0, cpu_cur.dout});
        check("timeout_err", {31'd0, TIMEOUT_ERR}, {31'd0, cpu_cur.err});
        check("dtack_cycle", cyc, cpu_cur.cyc);
      end
    end
    dt_prev = RESET ? 1'b1 : CPU_DTACKn;
  end

  task automatic wait_dtack(input logic level, input int unsigned bound, input string name);
    int unsigned i = 0;
    while (CPU_DTACKn !== level && i < bound) begin
      @(negedge CLK);
      i++;
    end
    check(name, {31'd0, CPU_DTACKn}, {31'd0, level});
  endtask

  // One full CPU bus cycle; expected results come from the access rules.
  task automatic do_access(input logic [2:0] addr, input logic rnw, input logic [15:0] din,
                           input int unsigned delay, input logic [15:0] rdata);
    logic [5:0]  eop;
    int unsigned lat;
    @(negedge CLK);
    rsp_delay = delay;
    rsp_data  = rdata;
    CPU_ADDR  = addr;
    CPU_RNW   = rnw;
    CPU_DIN   = din;
    CPU_CS    = 1'b1;
    eop = spec_op(addr, rnw);
    if (eop == 6'd0) begin
      lat = 1;
      m_dout = 16'hFFFF;
    end else begin
      gp_q.push_back('{op: eop, din: din});
      if (delay != 0 && delay <= 255) begin
        lat = 2 + delay;
        if (rnw) m_dout = rdata;
      end else begin
        lat = 2 + 255;
        m_dout = 16'hFFFF;
        m_err = 1'b1;
      end
    end
    cpu_q.push_back('{dout: m_dout, err: m_err, cyc: cyc + lat});
    wait_dtack(1'b0, 300, "dtack_assert");
    repeat ($urandom_range(2, 0)) @(negedge CLK);
    CPU_CS  = 1'b0;
    CPU_DIN = 16'($urandom);
    @(negedge CLK);
    check("dtack_release", {31'd0, CPU_DTACKn}, 32'd1);
    check("dout_hold", {16'd0, CPU_DOUT}, {16'd0, m_dout});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gpcs"}, {31'd0, GP9001CS}, 32'd0);
    check({tag, "_ops"}, {26'd0, ops}, 32'd0);
    check({tag, "_dtackn"}, {31'd0, CPU_DTACKn}, 32'd1);
    check({tag, "_dout"}, {16'd0, CPU_DOUT}, 32'd0);
    check({tag, "_gpdin"}, {16'd0, GP9001DIN}, 32'd0);
    check({tag, "_err"}, {31'd0, TIMEOUT_ERR}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned i;
    logic [2:0]  a;
    logic        r;
    int unsigned sel;
    int unsigned d;

    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;

    // Directed cases.
    do_access(3'b000, 1'b0, 16'h1234, 2, 16'h0000);
    do_access(3'b011, 1'b1, 16'h0000, 1, 16'hBEEF);
    do_access(3'b100, 1'b1, 16'h0000, 1, 16'h1111);
    do_access(3'b110, 1'b0, 16'h4321, 0, 16'h0000);
    do_access(3'b010, 1'b1, 16'h0000, 3, 16'hCAFE);
    do_access(3'b010, 1'b1, 16'h0000, 255, 16'h7E57);

    // CPU abandons the cycle before ACK; op still completes, no DTACK.
    @(negedge CLK);
    rsp_delay = 5;
    CPU_ADDR  = 3'b100;
    CPU_RNW   = 1'b0;
    CPU_DIN   = 16'h00A5;
    CPU_CS    = 1'b1;
    gp_q.push_back('{op: 6'b010000, din: 16'h00A5});
    repeat (2) @(negedge CLK);
    check("abort_cs_up", {31'd0, GP9001CS}, 32'd1);
    CPU_CS = 1'b0;
    i = 0;
    while (GP9001CS && i < 20) begin
      @(negedge CLK);
      i++;
    end
    check("abort_cs_drop", {31'd0, GP9001CS}, 32'd0);
    repeat (3) @(negedge CLK);
    check("abort_no_dtack", {31'd0, CPU_DTACKn}, 32'd1);
    check("abort_dout", {16'd0, CPU_DOUT}, {16'd0, m_dout});
    do_access(3'b010, 1'b0, 16'h5678, 2, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a   = 3'($urandom_range(7, 0));
      r   = 1'($urandom_range(1, 0));
      sel = $urandom_range(24, 0);
      d   = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(6, 1);
      do_access(a, r, 16'($urandom), d, 16'($urandom));
    end

    // Asynchronous reset while waiting on ACK.
    @(negedge CLK);
    rsp_delay = 0;
    CPU_ADDR  = 3'b110;
    CPU_RNW   = 1'b0;
    CPU_DIN   = 16'h5A5A;
    CPU_CS    = 1'b1;
    gp_q.push_back('{op: 6'b100000, din: 16'h5A5A});
    i = 0;
    while (!GP9001CS && i < 10) begin
      @(negedge CLK);
      i++;
    end
    check("rst_gpcs_up", {31'd0, GP9001CS}, 32'd1);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("midreset");
    CPU_CS = 1'b0;
    m_dout = '0;
    m_err  = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    do_access(3'b010, 1'b1, 16'h0000, 1, 16'hA11E);
    do_access(3'b000, 1'b0, 16'h0F0F, 4, 16'h0000);

    repeat (3) @(negedge CLK);
    check("sb_cpu_empty", cpu_q.size(), 32'd0);
    check("sb_gp_empty", gp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raizing_gp9001_bridge.md
Name: raizing_gp9001_bridge

Overview:
- CPU-side initiator for the GP9001 graphics controller command interface.
- Converts decoded 68000 bus cycles inside the GP9001 window into single-cycle op strobes, GP9001CS, and write data.
- Waits for GP9001ACK, returns read data, and drives DTACK back to the CPU.
- Sits in the main CPU memory map, between the 68000 bus decoder and the video subsystem's GP9001 port.

Parameters:
- TIMEOUT, 255: cycles to wait for GP9001ACK before forcing completion; 8-bit counter.
- UNMAPPED_DATA, 16'hFFFF: read data for unmapped offsets and for timed-out reads.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- CPU_CS  in  1  decoded GP9001 window select; high for the whole bus cycle.
- CPU_ADDR  in  3  CPU A[3:1], word offset within the window.
- CPU_RNW  in  1  1 = read, 0 = write.
- CPU_DIN  in  16  CPU write data.
- CPU_DOUT  out  16  read data to CPU; valid while CPU_DTACKn is low.
- CPU_DTACKn  out  1  active-low cycle acknowledge.
- GP9001CS  out  1  request to GP9001; held until ACK.
- GP9001ACK  in  1  GP9001 completion.
- GP9001DIN  out  16  write data to GP9001.
- GP9001DOUT  in  16  read data from GP9001; valid with ACK.
- GP9001_OP_SET_RAM_PTR, GP9001_OP_WRITE_RAM, GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG  out  1 each  op selects, one-hot, held with GP9001CS.
- TIMEOUT_ERR  out  1  sticky flag; cleared only by RESET.

Behaviour:
- Offset decode (CPU_ADDR, RNW):
  - 000 write -> SET_RAM_PTR.
  - 010 or 011 write -> WRITE_RAM.
  - 010 read -> READ_RAM_H.
  - 011 read -> READ_RAM_L.
  - 100 write -> SELECT_REG.
  - 110 write -> WRITE_REG.
  - All other offset/direction combinations are unmapped.
- Reset values: CPU_DTACKn=1, CPU_DOUT=0, GP9001CS=0, all op selects=0, GP9001DIN=0, TIMEOUT_ERR=0, FSM=IDLE, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE: on the rising edge of CPU_CS (registered CPU_CS previous value 0, current 1):
  - Mapped offset: latch op, CPU_ADDR and CPU_DIN; go to ISSUE.
  - Unmapped offset: load CPU_DOUT=UNMAPPED_DATA, assert DTACKn=0, go to DONE. GP9001CS is never asserted.
- ISSUE: next cycle, assert GP9001CS=1, the one-hot op and GP9001DIN; clear the counter; go to WAIT_ACK.
- WAIT_ACK: hold GP9001CS, op and data stable; increment the counter each cycle.
  - GP9001ACK=1: drop GP9001CS and op the same cycle. For reads, register CPU_DOUT=GP9001DOUT. Assert DTACKn=0 and go to DONE.
  - Counter reaches TIMEOUT with no ACK: drop CS; CPU_DOUT=UNMAPPED_DATA; set TIMEOUT_ERR; DTACKn=0; go to DONE.
  - ACK arriving in the same cycle the counter reaches TIMEOUT: ACK wins and TIMEOUT_ERR is not set.
- DONE: hold DTACKn=0 and CPU_DOUT until CPU_CS=0, then DTACKn=1 and go to IDLE. CPU_DOUT keeps its value.
- Latency: mapped access with ACK in the cycle after CS asserts gives DTACKn low 3 cycles after the CPU_CS rise (CPU_CS rise/latch -> ISSUE -> ACK -> DTACK).
- CPU_CS drops mid-operation (ISSUE or WAIT_ACK): the GP9001 transaction still completes or times out; then DONE exits immediately with no DTACK pulse carried into the next cycle.
- A new CPU_CS rise is ignored unless the FSM is in IDLE.
- Byte strobes are not modelled: byte writes are forwarded as full-word writes of CPU_DIN.
- The GP9001 is never issued more than one op per CPU bus cycle.
- RESET asserted mid-operation: every output returns to its reset value immediately (asynchronous). Any in-flight GP9001 op is abandoned.

Decomposition:
- Shared package raizing_gp9001_pkg:
  - op enum (one-hot, 6 bits);
  - offset localparams OFS_PTR=3'b000, OFS_DATA_H=3'b010, OFS_DATA_L=3'b011, OFS_SEL=3'b100, OFS_REG=3'b110;
  - FSM state encoding.
- One natural sub-module: raizing_gp9001_decode, a combinational offset/RNW -> {op, mapped} decoder, reusable by a Z80-side bridge.

Test Plan:
- Write 16'h1234 at offset 000 -> SET_RAM_PTR=1 and GP9001DIN=16'h1234 while GP9001CS high; ACK after 2 cycles -> DTACKn low; DTACKn returns to 1 after CPU_CS drops.
- Read offset 011, GP9001DOUT=16'hBEEF with ACK -> READ_RAM_L asserted; CPU_DOUT=16'hBEEF when DTACKn falls; no other op asserted.
- Read offset 100 (unmapped) -> GP9001CS stays 0; CPU_DOUT=16'hFFFF; DTACKn low 1 cycle after the CPU_CS rise.
- Write offset 110 with ACK never asserted, TIMEOUT=255 -> after 255 WAIT_ACK cycles CS drops, TIMEOUT_ERR=1, DTACKn=0; TIMEOUT_ERR stays set across later good accesses.
- Write offset 100, then drop CPU_CS before ACK; ACK 5 cycles later -> SELECT_REG held until ACK; FSM returns to IDLE; next access at offset 010 write issues WRITE_RAM normally.
- Assert RESET while in WAIT_ACK -> GP9001CS, op selects and DTACKn go to reset values in the same cycle; FSM in IDLE after RESET releases.
